// File: rtl/load_unit_pkg.sv
// Shared definitions for the byte-serial load unit: funct3 encodings,
// FSM states and small decode helpers.
package load_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Misaligned halfword/word or an encoding that is not a load.
  function automatic logic load_err(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return addr_lo[0];
      F3_LW:         return addr_lo != 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
module load_extend
  import load_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){word_i[7]}},   word_i[7:0]};
      F3_LH:   data_o = {{(XLEN-16){word_i[15]}}, word_i[15:0]};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}},        word_i[7:0]};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}},       word_i[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Byte-serial load unit: reads N bytes one access at a time, assembles them
// little-endian, extends the result and returns it with its rd index.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rd,
  output logic            mem_re,
  output logic [XLEN-1:0] mem_addr,
  input  logic [7:0]      mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd,
  output logic            rsp_err,
  output logic            busy
);

  localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

  state_e          state_q;
  logic [XLEN-1:0] base_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [1:0]      k_q;
  logic [1:0]      last_q;
  logic [1:0]      wcnt_q;
  logic [XLEN-1:0] asm_q;
  logic [XLEN-1:0] asm_d;
  logic [XLEN-1:0] ext_data;

  logic            mem_re_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_data_q;
  logic [4:0]      rsp_rd_q;
  logic            rsp_err_q;
  logic            busy_q;
  logic            ready_q;

  // Word as it will look once the current byte is captured; feeds both the
  // assembly register and the extender so the final byte lands in rsp_data.
  always_comb begin
    asm_d = asm_q;
    asm_d[{k_q, 3'b000} +: 8] = mem_rdata;
  end

  load_extend #(.XLEN(XLEN)) u_extend (
    .word_i   (asm_d),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      k_q         <= '0;
      last_q      <= '0;
      wcnt_q      <= '0;
      asm_q       <= '0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            base_q  <= req_addr;
            f3_q    <= req_funct3;
            rd_q    <= req_rd;
            last_q  <= 2'(byte_count(req_funct3) - 3'd1);
            k_q     <= '0;
            wcnt_q  <= '0;
            asm_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            if (load_err(req_funct3, req_addr[1:0])) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              rsp_rd_q    <= req_rd;
            end else begin
              state_q    <= S_ISSUE;
              mem_re_q   <= 1'b1;
              mem_addr_q <= req_addr;
            end
          end
        end
        S_ISSUE: begin
          mem_re_q <= 1'b0;
          wcnt_q   <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt_q == WAIT_LAST) begin
            asm_q <= asm_d;
            if (k_q == last_q) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= ext_data;
              rsp_rd_q    <= rd_q;
            end else begin
              k_q        <= k_q + 2'd1;
              mem_re_q   <= 1'b1;
              mem_addr_q <= base_q + XLEN'(k_q + 2'd1);
              state_q    <= S_ISSUE;
            end
          end else begin
            wcnt_q <= wcnt_q + 2'd1;
          end
        end
        S_DONE: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: two instances (MEM_LAT 1 and 3), directed and random
// loads checked against a byte-array memory and an arithmetic load model.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic [31:0] req_addr   [2];
  logic [2:0]  req_funct3 [2];
  logic [4:0]  req_rd     [2];
  logic        req_ready  [2];
  logic        mem_re     [2];
  logic [31:0] mem_addr   [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_data   [2];
  logic [4:0]  rsp_rd     [2];
  logic        rsp_err    [2];
  logic        busy       [2];

  logic [7:0]  mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [7:0]  rdata;
    logic [31:0] pa [LAT];
    logic        pv [LAT];

    load_unit #(.XLEN(32), .MEM_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .req_funct3 (req_funct3[g]),
      .req_rd     (req_rd[g]),
      .mem_re     (mem_re[g]),
      .mem_addr   (mem_addr[g]),
      .mem_rdata  (rdata),
      .rsp_valid  (rsp_valid[g]),
      .rsp_data   (rsp_data[g]),
      .rsp_rd     (rsp_rd[g]),
      .rsp_err    (rsp_err[g]),
      .busy       (busy[g])
    );

    // Memory model: data for a strobe appears LAT cycles after it, junk otherwise.
    initial begin
      rdata = '0;
      for (int i = 0; i < int'(LAT); i++) begin pa[i] = '0; pv[i] = 1'b0; end
    end
    always @(posedge clk) begin
      for (int i = int'(LAT) - 1; i > 0; i--) begin
        pa[i] = pa[i-1];
        pv[i] = pv[i-1];
      end
      pa[0] = mem_addr[g];
      pv[0] = mem_re[g];
      #1;
      rdata = pv[LAT-1] ? mem[pa[LAT-1][9:0]] : 8'($urandom);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  // Reference: load semantics computed with plain arithmetic over the byte array.
  function automatic void ref_load(input logic [31:0] addr, input logic [2:0] f3,
                                   output bit err, output int n, output logic [31:0] val);
    logic [31:0] a;
    logic [63:0] acc;
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
          ((f3 == 3'b001 || f3 == 3'b101) && (addr % 2 != 0)) ||
          ((f3 == 3'b010) && (addr % 4 != 0));
    n = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      acc = acc + (64'(mem[a % 1024]) << (8 * k));
    end
    if (f3 == 3'b000 && acc >= 128)   acc = acc + 64'hFFFF_FFFF_FFFF_FF00;
    if (f3 == 3'b001 && acc >= 32768) acc = acc + 64'hFFFF_FFFF_FFFF_0000;
    val = err ? 32'h0 : acc[31:0];
  endfunction

  // Called at a negedge in an idle cycle (C0). Returns at the negedge after DONE.
  task automatic do_load(input int idx, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [4:0] rd, input bit chain, input logic [31:0] naddr,
                         input logic [2:0] nf3, input logic [4:0] nrd);
    bit          err;
    int          n, done, lat, per;
    logic [31:0] exp;
    bit          exp_re;
    lat = lat_of(idx);
    per = 1 + lat;
    ref_load(addr, f3, err, n, exp);
    done = err ? 1 : n * per + 1;
    req_valid[idx]  = 1'b1;
    req_addr[idx]   = addr;
    req_funct3[idx] = f3;
    req_rd[idx]     = rd;
    check_eq("ready_c0", 32'(req_ready[idx]), 32'd1);
    for (int c = 1; c <= done; c++) begin
      @(negedge clk);
      if (chain) begin
        req_valid[idx]  = 1'b1;
        req_addr[idx]   = naddr;
        req_funct3[idx] = nf3;
        req_rd[idx]     = nrd;
      end else begin
        req_valid[idx]  = 1'($urandom);
        req_addr[idx]   = $urandom;
        req_funct3[idx] = 3'($urandom);
        req_rd[idx]     = 5'($urandom);
      end
      if (c == done && !chain) req_valid[idx] = 1'b0;
      exp_re = !err && c < done && ((c - 1) % per == 0);
      check_eq("mem_re", 32'(mem_re[idx]), 32'(exp_re));
      if (exp_re) check_eq("mem_addr", mem_addr[idx], addr + 32'((c - 1) / per));
      check_eq("busy", 32'(busy[idx]), 32'd1);
      check_eq("ready_busy", 32'(req_ready[idx]), 32'd0);
      check_eq("rsp_valid", 32'(rsp_valid[idx]), 32'(c == done));
    end
    check_eq("rsp_data", rsp_data[idx], exp);
    check_eq("rsp_rd", 32'(rsp_rd[idx]), 32'(rd));
    check_eq("rsp_err", 32'(rsp_err[idx]), 32'(err));
    @(negedge clk);
    check_eq("rsp_valid_drop", 32'(rsp_valid[idx]), 32'd0);
    check_eq("busy_drop", 32'(busy[idx]), 32'd0);
    check_eq("ready_back", 32'(req_ready[idx]), 32'd1);
    check_eq("rsp_data_hold", rsp_data[idx], exp);
    check_eq("mem_re_idle", 32'(mem_re[idx]), 32'd0);
  endtask

  task automatic single(input int idx, input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
    do_load(idx, addr, f3, rd, 1'b0, 32'h0, 3'h0, 5'h0);
  endtask

  task automatic check_reset_state(input int idx);
    check_eq("rst_mem_re", 32'(mem_re[idx]), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid[idx]), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err[idx]), 32'd0);
    check_eq("rst_busy", 32'(busy[idx]), 32'd0);
    check_eq("rst_ready", 32'(req_ready[idx]), 32'd1);
    check_eq("rst_mem_addr", mem_addr[idx], 32'd0);
    check_eq("rst_rsp_data", rsp_data[idx], 32'd0);
    check_eq("rst_rsp_rd", 32'(rsp_rd[idx]), 32'd0);
  endtask

  // Start an LW at 0x100 and pull reset in the middle of cycle C(cyc).
  task automatic reset_mid_load(input int idx, input int cyc);
    req_valid[idx]  = 1'b1;
    req_addr[idx]   = 32'h100;
    req_funct3[idx] = 3'b010;
    req_rd[idx]     = 5'd9;
    for (int c = 1; c <= cyc; c++) begin
      @(negedge clk);
      req_valid[idx] = 1'b0;
    end
    check_eq("pre_rst_busy", 32'(busy[idx]), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_state(idx);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_no_rsp", 32'(rsp_valid[idx]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("after_rst_no_rsp", 32'(rsp_valid[idx]), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 32'h100 + 32'($urandom_range(0, 15));
      1:       return $urandom;
      default: return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ca, na;
    logic [2:0]  cf, nf;
    logic [4:0]  cr, nr;
    bit          chain;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_funct3[i] = '0; req_rd[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    rst = 1'b1;
    @(negedge clk);

    for (int idx = 0; idx < 2; idx++) begin
      mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
      single(idx, 32'h100, 3'b010, 5'd5);
      mem[32'h101] = 8'h80;
      single(idx, 32'h101, 3'b000, 5'd1);
      single(idx, 32'h101, 3'b100, 5'd2);
      mem[32'h102] = 8'h34; mem[32'h103] = 8'hF2;
      single(idx, 32'h102, 3'b001, 5'd3);
      single(idx, 32'h102, 3'b101, 5'd4);
      single(idx, 32'h102, 3'b010, 5'd6);
      single(idx, 32'h101, 3'b001, 5'd7);
      single(idx, 32'h100, 3'b011, 5'd8);
      single(idx, 32'h100, 3'b000, 5'd0);
      mem[32'h101] = 8'h56; mem[32'h103] = 8'h12;
      reset_mid_load(idx, (idx == 0) ? 4 : 5);
      single(idx, 32'h100, 3'b000, 5'd10);
      do_load(idx, 32'h100, 3'b010, 5'd11, 1'b1, 32'h101, 3'b100, 5'd12);
      single(idx, 32'h101, 3'b100, 5'd12);

      ca = rand_addr(); cf = 3'($urandom); cr = 5'($urandom);
      for (int t = 0; t < 40; t++) begin
        na = rand_addr(); nf = 3'($urandom); nr = 5'($urandom);
        chain = 1'($urandom);
        do_load(idx, ca, cf, cr, chain, na, nf, nr);
        ca = na; cf = nf; cr = nr;
      end
      req_valid[idx] = 1'b0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
